prod_acc_tree: RTL and testbench
================================

# prod_acc_tree

Pipelined consumer of the 16-lane mantissa product bus produced by the PE multiplier array. Each cycle it accepts one vector of 16 signed products and reduces it through a registered 4-level adder tree. It then accumulates the vector sums across a first/last-delimited dot-product sequence and presents the accumulated result with a one-cycle valid pulse. It sits directly downstream of the multiplier array inside the 16-input accumulating PE.

## Interface
- `PW`, default 26: width of each product lane, two's complement.
- `ACC_W`, default 40: accumulator width; must be ≥ `PW+4`.
- `i_clk`  in  1  clock; all state updates on its rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_valid`  in  1  product vector present this cycle.
- `i_first`  in  1  vector starts a new accumulation; qualified by `i_valid`.
- `i_last`  in  1  vector ends the accumulation; qualified by `i_valid`.
- `i_stall`  in  1  freeze the whole block.
- `i_prod`  in  16*PW  lane k is at `[k*PW +: PW]`, signed.
- `o_valid`  out  1  one-cycle pulse: `o_acc` holds the final result of a sequence.
- `o_acc`  out  ACC_W  running accumulator value, signed.
- `o_ovf`  out  1  sticky signed-overflow flag for the current sequence.

## Operation
- **Accept.** A vector is accepted on an edge where `i_valid=1` and `i_stall=0`. `i_first` and `i_last` travel with it through a valid/first/last shadow pipeline.
- **Reduction stages.**
  - L1: 8 pair sums, PW+1 bits, computed from `i_prod` at accept time.
  - L2: 4 sums, PW+2 bits.
  - L3: 2 sums, PW+3 bits.
  - L4: 1 total, PW+4 bits.
  - Every level sign-extends its operands; no precision is lost.
- **Accumulate stage.** The total is sign-extended to `ACC_W`.
  - Tagged first: `acc <= total`, `o_ovf <= 0`.
  - Otherwise: `acc <= acc + total`. Signed overflow (operands share a sign, result sign differs) sets `o_ovf`.
- **Result.** `o_valid` pulses when the vector tagged last is accumulated.
- **Sequence boundaries.**
  - `i_first` and `i_last` on the same vector give a single-vector result: `o_acc = total`.
  - A vector with neither flag and no prior first accumulates onto the existing `acc` (0 after reset).
  - A new first while a sequence is still open discards the old sum without emitting it.
  - Back-to-back sequences (last, then first on the next cycle) are supported at full rate.
- **Bubbles.** An `i_valid=0` cycle inserts a bubble; bubbles never modify `acc` or `o_ovf`.

## Timing
- Throughput: one vector per non-stalled cycle.
- Latency: a vector accepted at edge N registers L1 at N, L2 at N+1, L3 at N+2, L4 at N+3, and the accumulator at N+4. `o_valid`/`o_acc` are visible after edge N+4, i.e. 5 edges.
- `o_valid` is high for exactly one non-stalled cycle per last-tagged vector.
- Stall: with `i_stall=1` every tree register, shadow bit, `acc`, `o_ovf` and `o_valid` holds its value. An `o_valid` pulse that is already up stays up until the first non-stalled edge, then clears.
- Reset values: all tree registers 0, shadow valid/first/last 0, `o_valid=0`, `o_acc=0`, `o_ovf=0`.
- Reset asserted mid-sequence discards every in-flight vector and the accumulator. No `o_valid` is produced for discarded vectors.

## Configuration
- Macro: `PROD_ACC_SAT_EN`.
- **Defined.** On overflow `acc` clamps to `2^(ACC_W-1)-1` (positive overflow) or `-2^(ACC_W-1)` (negative overflow), and `o_ovf` is set. Subsequent adds in the same sequence start from the clamped value.
- **Undefined.** `acc` wraps modulo `2^ACC_W`; `o_ovf` is still set, as sticky detection only.
- Default build leaves the macro undefined.

## Test plan
- All 16 lanes = 100, `i_first=i_last=1`, one cycle → `o_valid` 5 edges later, `o_acc=1600`, `o_ovf=0`.
- Lanes alternate +33554431 / −33554432, single-vector sequence → `o_acc=−8`. All lanes = −33554432 → `o_acc=−536870912`.
- Three vectors of all lanes = 1, 2, 3, with first on vector 1 and last on vector 3, sent back-to-back and followed immediately by a one-vector sequence of all lanes = 5:
  - `o_valid` pulses exactly twice, one cycle apart.
  - `o_acc` reads 96, then 80.
- Same three-vector sequence with `i_stall` high for 3 cycles mid-pipeline and an `i_valid=0` bubble between vectors 2 and 3 → result still 96; `o_valid` is delayed by exactly the stall plus bubble cycles.
- `ACC_W=32`, five vectors of all lanes = 33554431:
  - Without the macro: `o_acc=−1610612816`, `o_ovf=1`.
  - With `PROD_ACC_SAT_EN`: `o_acc=2147483647`, `o_ovf=1`.
  - A following first-tagged vector clears `o_ovf`.
- Assert `i_rst` two cycles after a last-tagged vector is accepted → no `o_valid`; `o_acc=0` and `o_ovf=0` immediately (asynchronous); normal operation resumes on the first edge after release.

Source files
------------

// File: rtl/prod_acc_tree.sv
// prod_acc_tree: 16-lane product adder tree feeding a first/last accumulator.
// Define PROD_ACC_SAT_EN to clamp the accumulator on signed overflow.
module prod_acc_tree #(
  parameter int PW    = 26,
  parameter int ACC_W = 40
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  input  logic                    i_first,
  input  logic                    i_last,
  input  logic                    i_stall,
  input  logic [16*PW-1:0]        i_prod,
  output logic                    o_valid,
  output logic signed [ACC_W-1:0] o_acc,
  output logic                    o_ovf
);

  localparam int MSB = ACC_W - 1;

  typedef struct packed {
    logic v;
    logic f;
    logic l;
  } tag_t;

  tag_t tag1, tag2, tag3, tag4;

  logic [7:0][PW:0]   s1, n1;
  logic [3:0][PW+1:0] s2, n2;
  logic [1:0][PW+2:0] s3, n3;
  logic [PW+3:0]      s4, n4;

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      n1[k] = {i_prod[(2*k+1)*PW-1], i_prod[2*k*PW +: PW]}
            + {i_prod[(2*k+2)*PW-1], i_prod[(2*k+1)*PW +: PW]};
    end
    for (int k = 0; k < 4; k++) begin
      n2[k] = {s1[2*k][PW], s1[2*k]}
            + {s1[2*k+1][PW], s1[2*k+1]};
    end
    for (int k = 0; k < 2; k++) begin
      n3[k] = {s2[2*k][PW+1], s2[2*k]}
            + {s2[2*k+1][PW+1], s2[2*k+1]};
    end
    n4 = {s3[0][PW+2], s3[0]} + {s3[1][PW+2], s3[1]};
  end

  // Data registers only load behind a valid tag to avoid toggling on bubbles.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tag1 <= '0;
      tag2 <= '0;
      tag3 <= '0;
      tag4 <= '0;
      s1   <= '0;
      s2   <= '0;
      s3   <= '0;
      s4   <= '0;
    end else if (!i_stall) begin
      tag1 <= '{v: i_valid,
                f: i_valid & i_first,
                l: i_valid & i_last};
      tag2 <= tag1;
      tag3 <= tag2;
      tag4 <= tag3;
      if (i_valid) s1 <= n1;
      if (tag1.v)  s2 <= n2;
      if (tag2.v)  s3 <= n3;
      if (tag3.v)  s4 <= n4;
    end
  end

  logic [ACC_W-1:0] tot_ext;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] acc_nxt;
  logic             ovf_hit;

  always_comb begin
    tot_ext = ACC_W'($signed(s4));
    sum     = o_acc + tot_ext;
    ovf_hit = (o_acc[MSB] == tot_ext[MSB])
            && (sum[MSB] != o_acc[MSB]);
`ifdef PROD_ACC_SAT_EN
    if (ovf_hit)
      acc_nxt = o_acc[MSB] ? {1'b1, {(ACC_W-1){1'b0}}}
                           : {1'b0, {(ACC_W-1){1'b1}}};
    else
      acc_nxt = sum;
`else
    acc_nxt = sum;
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_acc   <= '0;
      o_ovf   <= 1'b0;
    end else if (!i_stall) begin
      o_valid <= tag4.v & tag4.l;
      if (tag4.v) begin
        if (tag4.f) begin
          o_acc <= tot_ext;
          o_ovf <= 1'b0;
        end else begin
          o_acc <= acc_nxt;
          o_ovf <= o_ovf | ovf_hit;
        end
      end
    end
  end

endmodule

// File: tb/tb_prod_acc_tree.sv
// tb_prod_acc_tree: directed vectors for prod_acc_tree.
// Runs a default instance and an ACC_W=32 instance on shared stimulus.
module tb_prod_acc_tree;

  localparam int PW = 26;

  logic clk = 1'b0;
  logic rst, valid, first, last, stall;
  logic [16*PW-1:0] prod;

  logic              v40, ovf40, v32, ovf32;
  logic signed [39:0] acc40;
  logic signed [31:0] acc32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prod_acc_tree #(.PW(PW), .ACC_W(40)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_valid(valid),
    .i_first(first),
    .i_last (last),
    .i_stall(stall),
    .i_prod (prod),
    .o_valid(v40),
    .o_acc  (acc40),
    .o_ovf  (ovf40)
  );

  prod_acc_tree #(.PW(PW), .ACC_W(32)) dut32 (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_valid(valid),
    .i_first(first),
    .i_last (last),
    .i_stall(stall),
    .i_prod (prod),
    .o_valid(v32),
    .o_acc  (acc32),
    .o_ovf  (ovf32)
  );

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input longint v);
    for (int k = 0; k < 16; k++) prod[k*PW +: PW] = v[PW-1:0];
  endtask

  task automatic send_cur(input logic f, input logic l);
    valid = 1'b1;
    first = f;
    last  = l;
    step();
    valid = 1'b0;
    first = 1'b0;
    last  = 1'b0;
  endtask

  task automatic send(input longint v, input logic f, input logic l);
    fill(v);
    send_cur(f, l);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; first = 1'b0;
    last = 1'b0; stall = 1'b0; prod = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", v40, 0);
    chk("rst_acc", acc40, 0);
    chk("rst_ovf", ovf40, 0);
    rst = 1'b0;

    // single vector, latency
    send(100, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t1_early", v40, 0);
    end
    step();
    chk("t1_valid", v40, 1);
    chk("t1_acc", acc40, 1600);
    chk("t1_ovf", ovf40, 0);
    step();
    chk("t1_pulse_end", v40, 0);

    // extreme lanes
    for (int k = 0; k < 16; k++)
      prod[k*PW +: PW] = (k % 2 == 0) ? 26'h1FFFFFF : 26'h2000000;
    send_cur(1, 1);
    repeat (4) step();
    chk("t2_alt", acc40, -8);
    send(-33554432, 1, 1);
    repeat (4) step();
    chk("t2_min", acc40, -536870912);
    chk("t2_min_ovf", ovf40, 0);

    // back-to-back sequences
    send(1, 1, 0);
    send(2, 0, 0);
    send(3, 0, 1);
    send(5, 1, 1);
    step();
    chk("t3_v_n4", v40, 0);
    chk("t3_acc_n4", acc40, 16);
    step();
    chk("t3_v_n5", v40, 0);
    chk("t3_acc_n5", acc40, 48);
    step();
    chk("t3_v_n6", v40, 1);
    chk("t3_acc_n6", acc40, 96);
    step();
    chk("t3_v_n7", v40, 1);
    chk("t3_acc_n7", acc40, 80);
    step();
    chk("t3_v_n8", v40, 0);

    // no-first continuation, then first discarding open sum
    send(1, 0, 1);
    repeat (4) step();
    chk("t3_cont", acc40, 96);
    send(4, 1, 0);
    send(2, 1, 1);
    repeat (4) step();
    chk("t3_restart_v", v40, 1);
    chk("t3_restart", acc40, 32);
    step();

    // stall and bubble
    send(1, 1, 0);
    send(2, 0, 0);
    step();
    send(3, 0, 1);
    stall = 1'b1;
    repeat (3) step();
    stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_early", v40, 0);
    end
    step();
    chk("t4_valid", v40, 1);
    chk("t4_acc", acc40, 96);
    stall = 1'b1;
    step();
    chk("t4_stall_hold", v40, 1);
    stall = 1'b0;
    step();
    chk("t4_pulse_end", v40, 0);

    // 32-bit accumulator overflow
    send(33554431, 1, 0);
    repeat (3) send(33554431, 0, 0);
    send(33554431, 0, 1);
    repeat (4) step();
    chk("t5_v32", v32, 1);
`ifdef PROD_ACC_SAT_EN
    chk("t5_acc32", acc32, 2147483647);
`else
    chk("t5_acc32", acc32, -1610612816);
`endif
    chk("t5_ovf32", ovf32, 1);
    chk("t5_acc40", acc40, 64'sd2684354480);
    chk("t5_ovf40", ovf40, 0);
    send(1, 1, 1);
    repeat (4) step();
    chk("t5_clr_acc", acc32, 16);
    chk("t5_clr_ovf", ovf32, 0);

    // asynchronous reset mid-flight
    send(33554431, 1, 0);
    repeat (4) send(33554431, 0, 0);
    repeat (2) step();
    send(7, 0, 1);
    repeat (2) step();
    chk("t6_pre_ovf", ovf32, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_acc40", acc40, 0);
    chk("t6_rst_acc32", acc32, 0);
    chk("t6_rst_ovf", ovf32, 0);
    chk("t6_rst_v", v40, 0);
    repeat (2) step();
    rst = 1'b0;
    send(2, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_no_ghost", v40, 0);
    end
    step();
    chk("t6_resume_v", v40, 1);
    chk("t6_resume_acc", acc40, 32);
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
